// File: rtl/ber_accumulator_if.sv
// Word stream, run control and result bundle between the BER host
// logic and the accumulator.
interface ber_accumulator_if #(
    parameter int WIN_W = 32,
    parameter int ERR_W = 40
);
    logic             en;
    logic [8:0]       err_num;
    logic             lock;
    logic             start;
    logic             stop;
    logic [WIN_W-1:0] window;
    logic [WIN_W-1:0] word_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [15:0]      lol_cnt;
    logic             busy;
    logic             done;
    logic             sat;

    modport master (
        output en, err_num, lock, start, stop, window,
        input  word_cnt, err_cnt, lol_cnt, busy, done, sat
    );

    modport slave (
        input  en, err_num, lock, start, stop, window,
        output word_cnt, err_cnt, lol_cnt, busy, done, sat
    );
endinterface

// File: rtl/ber_accumulator.sv
// Lock-qualified measurement window that accumulates words, bit errors
// and loss-of-lock events from the PRBS checker.
module ber_accumulator #(
    parameter int WIN_W    = 32,
    parameter int ERR_W    = 40,
    parameter int LOCK_CYC = 16
) (
    input logic               clk,
    input logic               reset,
    ber_accumulator_if.slave  bus
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;
    localparam logic [7:0] LOCK_Q    = 8'(LOCK_CYC);

    logic [1:0]       state;
    logic [7:0]       qual;
    logic             prev_lock;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] word_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [15:0]      lol_cnt;
    logic             sat;

    logic [7:0]       qual_inc;
    logic             qual_hit;
    logic             word_full;
    logic [WIN_W-1:0] word_next;
    logic             win_hit;
    logic [ERR_W:0]   err_sum;
    logic             err_ovf;
    logic [ERR_W-1:0] err_next;
    logic             lol_evt;
    logic             lol_full;

    assign qual_inc  = qual + 8'd1;
    assign qual_hit  = (qual_inc == LOCK_Q);
    assign word_full = &word_cnt;
    assign word_next = word_full ? word_cnt : word_cnt + WIN_W'(1);
    // a zero window means run until stop, so it never matches here
    assign win_hit   = (win_q != '0) && (word_next == win_q);
    assign err_sum   = {1'b0, err_cnt} + (ERR_W+1)'(bus.err_num);
    assign err_ovf   = err_sum[ERR_W];
    assign err_next  = err_ovf ? '1 : err_sum[ERR_W-1:0];
    assign lol_evt   = prev_lock & ~bus.lock;
    assign lol_full  = &lol_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            qual      <= '0;
            prev_lock <= 1'b0;
            win_q     <= '0;
            word_cnt  <= '0;
            err_cnt   <= '0;
            lol_cnt   <= '0;
            sat       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= WAIT_LOCK;
                        qual     <= '0;
                        win_q    <= bus.window;
                        word_cnt <= '0;
                        err_cnt  <= '0;
                        lol_cnt  <= '0;
                        sat      <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (bus.stop) begin
                        state <= IDLE;
                    end else if (bus.en) begin
                        if (bus.lock) begin
                            qual <= qual_inc;
                            if (qual_hit) begin
                                state     <= MEASURE;
                                prev_lock <= 1'b1;
                            end
                        end else begin
                            qual <= '0;
                        end
                    end
                end
                MEASURE: begin
                    if (bus.en) begin
                        word_cnt  <= word_next;
                        err_cnt   <= err_next;
                        prev_lock <= bus.lock;
                        if (lol_evt && !lol_full)
                            lol_cnt <= lol_cnt + 16'd1;
                        if (word_full || err_ovf || (lol_evt && lol_full))
                            sat <= 1'b1;
                    end
                    if (bus.stop || (bus.en && win_hit))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.word_cnt = word_cnt;
    assign bus.err_cnt  = err_cnt;
    assign bus.lol_cnt  = lol_cnt;
    assign bus.sat      = sat;
    assign bus.busy     = (state == WAIT_LOCK) || (state == MEASURE);
    assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_ber_accumulator.sv
// Scoreboarded bench for ber_accumulator, with a narrow-ERR_W twin
// sharing the same stimulus.
module tb_ber_accumulator;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ber_accumulator_if #(.WIN_W(32), .ERR_W(40)) bus ();
    ber_accumulator_if #(.WIN_W(32), .ERR_W(8))  b8 ();

    ber_accumulator #(.WIN_W(32), .ERR_W(40), .LOCK_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ber_accumulator #(.WIN_W(32), .ERR_W(8), .LOCK_CYC(16)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8.slave)
    );

    assign b8.en      = bus.en;
    assign b8.err_num = bus.err_num;
    assign b8.lock    = bus.lock;
    assign b8.start   = bus.start;
    assign b8.stop    = bus.stop;
    assign b8.window  = bus.window;

    typedef struct {
        bit     chk_words;
        int     words;
        longint wc;
        longint ec;
        longint lc;
        bit     sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void pat(input int mode, input int i,
                                output logic l, output logic [8:0] e);
        l = 1'b1;
        e = 9'd0;
        case (mode)
            1: begin
                if (i < 16)
                    e = 9'd7;
                else if ((i - 16) % 10 == 9)
                    e = 9'd3;
            end
            2: l = (i != 9);
            3: if (i >= 16) e = 9'd200;
            default: ;
        endcase
    endfunction

    task automatic run(input int mode, input int bound, output int n);
        logic       l;
        logic [8:0] e;
        n = 0;
        while (n < bound) begin
            pat(mode, n, l, e);
            bus.en      = 1'b1;
            bus.lock    = l;
            bus.err_num = e;
            tick();
            n++;
            if (bus.done)
                break;
        end
        bus.en      = 1'b0;
        bus.err_num = 9'd0;
    endtask

    task automatic do_start(input logic [31:0] win);
        bus.window = win;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic word(input logic e_n, input logic l, input logic [8:0] e,
                        input logic stp, input logic sta);
        bus.en      = e_n;
        bus.lock    = l;
        bus.err_num = e;
        bus.stop    = stp;
        bus.start   = sta;
        tick();
        bus.en      = 1'b0;
        bus.err_num = 9'd0;
        bus.stop    = 1'b0;
        bus.start   = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int n);
        exp_t x;
        x = sb.pop_front();
        if (x.chk_words)
            chk({tag, ".words"}, n, x.words);
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".word_cnt"}, bus.word_cnt, x.wc);
        chk({tag, ".err_cnt"}, bus.err_cnt, x.ec);
        chk({tag, ".lol_cnt"}, bus.lol_cnt, x.lc);
        chk({tag, ".sat"}, bus.sat, x.sat);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".word_cnt"}, bus.word_cnt, 0);
        chk({tag, ".err_cnt"}, bus.err_cnt, 0);
        chk({tag, ".lol_cnt"}, bus.lol_cnt, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".sat"}, bus.sat, 0);
    endtask

    initial begin
        int n;
        bus.en      = 1'b0;
        bus.err_num = 9'd0;
        bus.lock    = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.window  = '0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_zero("rst");

        // clean window of 100 words
        do_start(32'd100);
        chk("s1.busy_after_start", bus.busy, 1);
        sb.push_back('{1, 116, 100, 0, 0, 0});
        run(0, 300, n);
        finish_check("s1", n);
        repeat (3) tick();
        chk("s1.hold_word_cnt", bus.word_cnt, 100);
        chk("s1.hold_done", bus.done, 1);

        // sparse errors; errors during qualification are discarded
        do_start(32'd100);
        chk("s2.cleared", bus.word_cnt, 0);
        sb.push_back('{1, 116, 100, 30, 0, 0});
        run(1, 300, n);
        finish_check("s2", n);

        // lock drop on word 10 restarts qualification
        do_start(32'd100);
        sb.push_back('{1, 126, 100, 0, 0, 0});
        run(2, 300, n);
        finish_check("s3", n);

        // start and stop together while waiting for lock: stop wins
        do_start(32'd0);
        word(1'b0, 1'b0, 9'd0, 1'b1, 1'b1);
        chk("s_ss.busy", bus.busy, 0);
        chk("s_ss.done", bus.done, 0);
        chk("s_ss.word_cnt", bus.word_cnt, 0);

        // continuous window, lock toggling, stop with a live word
        do_start(32'd0);
        run(0, 16, n);
        chk("s4.measuring", bus.busy, 1);
        chk("s4.entry_word_cnt", bus.word_cnt, 0);
        sb.push_back('{0, 0, 5, 5, 2, 0});
        word(1'b1, 1'b1, 9'd1, 1'b0, 1'b0);
        word(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);
        word(1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        word(1'b1, 1'b1, 9'd1, 1'b0, 1'b0);
        word(1'b1, 1'b0, 9'd1, 1'b0, 1'b0);
        chk("s4.pre_stop_lol", bus.lol_cnt, 2);
        word(1'b1, 1'b1, 9'd1, 1'b1, 1'b0);
        finish_check("s4", 0);

        // large error words: wide counter sums, narrow one clamps
        do_start(32'd2);
        sb.push_back('{1, 18, 2, 400, 0, 0});
        run(3, 100, n);
        finish_check("s5", n);
        chk("s5n.err_cnt", b8.err_cnt, 255);
        chk("s5n.sat", b8.sat, 1);
        chk("s5n.word_cnt", b8.word_cnt, 2);
        chk("s5n.done", b8.done, 1);

        // reset in the middle of a measurement
        do_start(32'd0);
        run(0, 66, n);
        chk("s6.mid_word_cnt", bus.word_cnt, 50);
        chk("s6.mid_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("s6.rst");
        tick();
        do_start(32'd100);
        sb.push_back('{1, 116, 100, 0, 0, 0});
        run(0, 300, n);
        finish_check("s6.rerun", n);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
